trap_ctrl: RTL and testbench

TRAP_CTRL -- requirements
Module: trap_ctrl

---
 rtl/trap_ctrl_if.sv | 38 +++
 rtl/trap_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 359 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trap_ctrl_if.sv
// Trap controller bus: commit-stage requests and CSR snapshots in,
// CSR write port and pipeline control out.
interface trap_ctrl_if;
  logic        exc_valid;
  logic [3:0]  exc_code;
  logic [31:0] trap_pc;
  logic        irq_ext;
  logic        irq_sw;
  logic        irq_timer;
  logic        mret;
  logic [31:0] mstatus;
  logic [31:0] mie;
  logic [31:0] mtvec;
  logic [31:0] mepc;

  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  modport master (
    output exc_valid, exc_code, trap_pc, irq_ext, irq_sw, irq_timer, mret,
           mstatus, mie, mtvec, mepc,
    input  csr_we, csr_waddr, csr_wdata, stall, flush, redirect_valid,
           redirect_pc, busy
  );

  modport slave (
    input  exc_valid, exc_code, trap_pc, irq_ext, irq_sw, irq_timer, mret,
           mstatus, mie, mtvec, mepc,
    output csr_we, csr_waddr, csr_wdata, stall, flush, redirect_valid,
           redirect_pc, busy
  );
endinterface

// File: rtl/trap_ctrl.sv
// Machine-mode trap/MRET sequencer: serialises mepc/mcause/mstatus updates
// through a single CSR write port, then redirects fetch.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | sampling exc/mret/irq requests
// W_MEPC    | writing mepc <= latched PC
// W_MCAUSE  | writing mcause <= latched cause
// W_MSTATUS | writing mstatus trap-entry image (MPIE<=MIE, MIE<=0, MPP=M)
// M_MSTATUS | writing mstatus MRET image (MIE<=MPIE, MPIE<=1, MPP=M)
// REDIRECT  | one-cycle flush + redirect, then back to IDLE
module trap_ctrl (
  input logic        clk,
  input logic        rst,
  trap_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    W_MEPC    = 3'd1,
    W_MCAUSE  = 3'd2,
    W_MSTATUS = 3'd3,
    M_MSTATUS = 3'd4,
    REDIRECT  = 3'd5
  } state_e;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] cause_q;
  logic [31:0] mstatus_q;
  logic [31:0] mtvec_q;
  logic        mret_q;

  logic        csr_we_q;
  logic [11:0] csr_waddr_q;
  logic [31:0] csr_wdata_q;
  logic        flush_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;
  logic        busy_q;

  logic        take_ext_d;
  logic        take_sw_d;
  logic        take_timer_d;
  logic        take_irq_d;
  logic [3:0]  irq_code_d;
  logic        accept_trap_d;
  logic        accept_mret_d;
  logic [31:0] cause_d;
  logic [31:0] tvec_base_d;
  logic [31:0] target_d;

  logic unused_mie;
  assign unused_mie = ^{bus.mie[31:12], bus.mie[10:8], bus.mie[6:4], bus.mie[2:0]};

  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r        = s;
    r[7]     = s[3];
    r[3]     = 1'b0;
    r[12:11] = 2'b11;
    return r;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r        = s;
    r[3]     = s[7];
    r[7]     = 1'b1;
    r[12:11] = 2'b11;
    return r;
  endfunction

  // Interrupt arbitration: global MIE gate, then ext > sw > timer.
  always_comb begin
    take_ext_d   = bus.mstatus[3] & bus.irq_ext   & bus.mie[11];
    take_sw_d    = bus.mstatus[3] & bus.irq_sw    & bus.mie[3];
    take_timer_d = bus.mstatus[3] & bus.irq_timer & bus.mie[7];
    take_irq_d   = take_ext_d | take_sw_d | take_timer_d;
    irq_code_d   = 4'd0;
    if (take_ext_d)
      irq_code_d = 4'd11;
    else if (take_sw_d)
      irq_code_d = 4'd3;
    else if (take_timer_d)
      irq_code_d = 4'd7;
  end

  // Exception beats MRET beats interrupt; a simultaneous MRET is dropped.
  always_comb begin
    accept_trap_d = 1'b0;
    accept_mret_d = 1'b0;
    if (state_q == IDLE) begin
      if (bus.exc_valid)
        accept_trap_d = 1'b1;
      else if (bus.mret)
        accept_mret_d = 1'b1;
      else if (take_irq_d)
        accept_trap_d = 1'b1;
    end
    cause_d = bus.exc_valid ? {28'b0, bus.exc_code} : {1'b1, 27'b0, irq_code_d};
  end

  // Vectored mode only offsets interrupts; exceptions always land on the base.
  always_comb begin
    tvec_base_d = {mtvec_q[31:2], 2'b00};
    if (mret_q)
      target_d = {pc_q[31:2], 2'b00};
    else if (mtvec_q[1:0] == 2'b01 && cause_q[31])
      target_d = tvec_base_d + {26'b0, cause_q[3:0], 2'b00};
    else
      target_d = tvec_base_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      pc_q             <= '0;
      cause_q          <= '0;
      mstatus_q        <= '0;
      mtvec_q          <= '0;
      mret_q           <= 1'b0;
      csr_we_q         <= 1'b0;
      csr_waddr_q      <= '0;
      csr_wdata_q      <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      busy_q           <= 1'b0;
    end else begin
      csr_we_q         <= 1'b0;
      csr_waddr_q      <= '0;
      csr_wdata_q      <= '0;
      flush_q          <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      case (state_q)
        IDLE: begin
          if (accept_trap_d) begin
            pc_q        <= bus.trap_pc;
            cause_q     <= cause_d;
            mstatus_q   <= bus.mstatus;
            mtvec_q     <= bus.mtvec;
            mret_q      <= 1'b0;
            busy_q      <= 1'b1;
            csr_we_q    <= 1'b1;
            csr_waddr_q <= ADDR_MEPC;
            csr_wdata_q <= bus.trap_pc;
            state_q     <= W_MEPC;
          end else if (accept_mret_d) begin
            pc_q        <= bus.mepc;
            mstatus_q   <= bus.mstatus;
            mret_q      <= 1'b1;
            busy_q      <= 1'b1;
            csr_we_q    <= 1'b1;
            csr_waddr_q <= ADDR_MSTATUS;
            csr_wdata_q <= mret_mstatus(bus.mstatus);
            state_q     <= M_MSTATUS;
          end
        end
        W_MEPC: begin
          csr_we_q    <= 1'b1;
          csr_waddr_q <= ADDR_MCAUSE;
          csr_wdata_q <= cause_q;
          state_q     <= W_MCAUSE;
        end
        W_MCAUSE: begin
          csr_we_q    <= 1'b1;
          csr_waddr_q <= ADDR_MSTATUS;
          csr_wdata_q <= trap_mstatus(mstatus_q);
          state_q     <= W_MSTATUS;
        end
        W_MSTATUS, M_MSTATUS: begin
          flush_q          <= 1'b1;
          redirect_valid_q <= 1'b1;
          redirect_pc_q    <= target_d;
          state_q          <= REDIRECT;
        end
        REDIRECT: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.csr_we         = csr_we_q;
  assign bus.csr_waddr      = csr_waddr_q;
  assign bus.csr_wdata      = csr_wdata_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.busy           = busy_q;
  // Reset forces stall low even while a request line is still held.
  assign bus.stall          = busy_q | (~rst & (accept_trap_d | accept_mret_d));

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: trap entry, interrupt gating/priority,
// MRET, exception-vs-MRET, mid-sequence reset and back-to-back requests.
module tb_trap_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  trap_ctrl_if bus ();

  trap_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.exc_valid = 1'b0;
    bus.exc_code  = 4'd0;
    bus.trap_pc   = 32'h0;
    bus.irq_ext   = 1'b0;
    bus.irq_sw    = 1'b0;
    bus.irq_timer = 1'b0;
    bus.mret      = 1'b0;
    bus.mstatus   = 32'h0;
    bus.mie       = 32'h0;
    bus.mtvec     = 32'h0;
    bus.mepc      = 32'h0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    #2;
    checks++;
    if ({bus.csr_we, bus.csr_waddr, bus.csr_wdata} !== 45'h0) begin
      failures++;
      $display("FAIL reset_csr got=%h want=0", {bus.csr_we, bus.csr_waddr, bus.csr_wdata});
    end
    checks++;
    if ({bus.stall, bus.flush, bus.redirect_valid, bus.redirect_pc, bus.busy} !== 36'h0) begin
      failures++;
      $display("FAIL reset_ctrl got=%h want=0",
               {bus.stall, bus.flush, bus.redirect_valid, bus.redirect_pc, bus.busy});
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.busy, bus.csr_we, bus.stall} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle got=%b want=000", {bus.busy, bus.csr_we, bus.stall});
    end
  endtask

  task automatic test_exception;
    clear_inputs();
    bus.mstatus   = 32'h88;
    bus.mtvec     = 32'h800;
    bus.exc_valid = 1'b1;
    bus.exc_code  = 4'd2;
    bus.trap_pc   = 32'h100;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      failures++;
      $display("FAIL exc_stall got=%b want=1", bus.stall);
    end
    tick();
    bus.exc_valid = 1'b0;
    checks++;
    if ({bus.csr_we, bus.csr_waddr, bus.csr_wdata, bus.busy} !== {1'b1, 12'h341, 32'h100, 1'b1}) begin
      failures++;
      $display("FAIL exc_mepc got=%b/%h/%h busy=%b want=1/341/00000100 busy=1",
               bus.csr_we, bus.csr_waddr, bus.csr_wdata, bus.busy);
    end
    tick();
    checks++;
    if ({bus.csr_we, bus.csr_waddr, bus.csr_wdata} !== {1'b1, 12'h342, 32'h2}) begin
      failures++;
      $display("FAIL exc_mcause got=%b/%h/%h want=1/342/00000002",
               bus.csr_we, bus.csr_waddr, bus.csr_wdata);
    end
    tick();
    checks++;
    if ({bus.csr_we, bus.csr_waddr, bus.csr_wdata} !== {1'b1, 12'h300, 32'h1880}) begin
      failures++;
      $display("FAIL exc_mstatus got=%b/%h/%h want=1/300/00001880",
               bus.csr_we, bus.csr_waddr, bus.csr_wdata);
    end
    tick();
    checks++;
    if ({bus.redirect_valid, bus.flush, bus.redirect_pc, bus.csr_we} !== {1'b1, 1'b1, 32'h800, 1'b0}) begin
      failures++;
      $display("FAIL exc_redirect got=rv%b fl%b pc%h we%b want=rv1 fl1 pc00000800 we0",
               bus.redirect_valid, bus.flush, bus.redirect_pc, bus.csr_we);
    end
    tick();
    checks++;
    if ({bus.redirect_valid, bus.flush, bus.busy, bus.csr_waddr, bus.csr_wdata} !== 47'h0) begin
      failures++;
      $display("FAIL exc_done got=rv%b fl%b busy%b addr%h data%h want=all 0",
               bus.redirect_valid, bus.flush, bus.busy, bus.csr_waddr, bus.csr_wdata);
    end
  endtask

  task automatic test_irq_timer;
    clear_inputs();
    bus.mstatus   = 32'h8;
    bus.mie       = 32'h80;
    bus.mtvec     = 32'h801;
    bus.trap_pc   = 32'h200;
    bus.irq_timer = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      failures++;
      $display("FAIL tmr_stall got=%b want=1", bus.stall);
    end
    tick();
    bus.irq_timer = 1'b0;
    checks++;
    if ({bus.csr_waddr, bus.csr_wdata} !== {12'h341, 32'h200}) begin
      failures++;
      $display("FAIL tmr_mepc got=%h/%h want=341/00000200", bus.csr_waddr, bus.csr_wdata);
    end
    tick();
    checks++;
    if ({bus.csr_we, bus.csr_waddr, bus.csr_wdata} !== {1'b1, 12'h342, 32'h80000007}) begin
      failures++;
      $display("FAIL tmr_mcause got=%b/%h/%h want=1/342/80000007",
               bus.csr_we, bus.csr_waddr, bus.csr_wdata);
    end
    tick();
    checks++;
    if ({bus.csr_waddr, bus.csr_wdata} !== {12'h300, 32'h1880}) begin
      failures++;
      $display("FAIL tmr_mstatus got=%h/%h want=300/00001880", bus.csr_waddr, bus.csr_wdata);
    end
    tick();
    checks++;
    if ({bus.redirect_valid, bus.redirect_pc} !== {1'b1, 32'h81C}) begin
      failures++;
      $display("FAIL tmr_redirect got=rv%b pc%h want=rv1 pc0000081c",
               bus.redirect_valid, bus.redirect_pc);
    end
    tick();
  endtask

  task automatic test_irq_masked;
    clear_inputs();
    bus.mstatus = 32'h0;
    bus.mie     = 32'h800;
    bus.irq_ext = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.csr_we, bus.stall, bus.busy} !== 3'b000) begin
        failures++;
        $display("FAIL mask_global cyc=%0d got=we%b st%b busy%b want=000",
                 i, bus.csr_we, bus.stall, bus.busy);
      end
      tick();
    end
    clear_inputs();
    bus.mstatus = 32'h8;
    bus.mie     = 32'h80;
    bus.irq_sw  = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({bus.csr_we, bus.stall, bus.busy} !== 3'b000) begin
        failures++;
        $display("FAIL mask_enable cyc=%0d got=we%b st%b busy%b want=000",
                 i, bus.csr_we, bus.stall, bus.busy);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_irq_priority;
    clear_inputs();
    bus.mstatus   = 32'h8;
    bus.mie       = 32'h888;
    bus.mtvec     = 32'h1001;
    bus.trap_pc   = 32'h60;
    bus.irq_ext   = 1'b1;
    bus.irq_sw    = 1'b1;
    bus.irq_timer = 1'b1;
    tick();
    clear_inputs();
    tick();
    checks++;
    if (bus.csr_wdata !== 32'h8000000B) begin
      failures++;
      $display("FAIL prio_mcause got=%h want=8000000b", bus.csr_wdata);
    end
    tick();
    tick();
    checks++;
    if (bus.redirect_pc !== 32'h102C) begin
      failures++;
      $display("FAIL prio_redirect got=%h want=0000102c", bus.redirect_pc);
    end
    tick();
  endtask

  task automatic test_mret;
    clear_inputs();
    bus.mstatus = 32'h1880;
    bus.mepc    = 32'h104;
    bus.mret    = 1'b1;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      failures++;
      $display("FAIL mret_stall got=%b want=1", bus.stall);
    end
    tick();
    bus.mret = 1'b0;
    checks++;
    if ({bus.csr_we, bus.csr_waddr, bus.csr_wdata} !== {1'b1, 12'h300, 32'h1888}) begin
      failures++;
      $display("FAIL mret_mstatus got=%b/%h/%h want=1/300/00001888",
               bus.csr_we, bus.csr_waddr, bus.csr_wdata);
    end
    tick();
    checks++;
    if ({bus.redirect_valid, bus.flush, bus.redirect_pc, bus.csr_we} !== {1'b1, 1'b1, 32'h104, 1'b0}) begin
      failures++;
      $display("FAIL mret_redirect got=rv%b fl%b pc%h we%b want=rv1 fl1 pc00000104 we0",
               bus.redirect_valid, bus.flush, bus.redirect_pc, bus.csr_we);
    end
    tick();
    checks++;
    if ({bus.busy, bus.redirect_valid} !== 2'b00) begin
      failures++;
      $display("FAIL mret_done got=%b want=00", {bus.busy, bus.redirect_valid});
    end
  endtask

  task automatic test_exc_mret_reset;
    clear_inputs();
    bus.mstatus   = 32'h88;
    bus.mtvec     = 32'h801;
    bus.mepc      = 32'h500;
    bus.trap_pc   = 32'h300;
    bus.exc_valid = 1'b1;
    bus.exc_code  = 4'd5;
    bus.mret      = 1'b1;
    tick();
    checks++;
    if ({bus.csr_waddr, bus.csr_wdata} !== {12'h341, 32'h300}) begin
      failures++;
      $display("FAIL both_mepc got=%h/%h want=341/00000300", bus.csr_waddr, bus.csr_wdata);
    end
    tick();
    checks++;
    if ({bus.csr_waddr, bus.csr_wdata} !== {12'h342, 32'h5}) begin
      failures++;
      $display("FAIL both_mcause got=%h/%h want=342/00000005", bus.csr_waddr, bus.csr_wdata);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.csr_we, bus.csr_waddr, bus.csr_wdata, bus.stall, bus.flush,
         bus.redirect_valid, bus.redirect_pc, bus.busy} !== 81'h0) begin
      failures++;
      $display("FAIL rst_mid got=we%b a%h d%h st%b fl%b rv%b pc%h busy%b want=all 0",
               bus.csr_we, bus.csr_waddr, bus.csr_wdata, bus.stall, bus.flush,
               bus.redirect_valid, bus.redirect_pc, bus.busy);
    end
    clear_inputs();
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({bus.csr_we, bus.busy, bus.redirect_valid} !== 3'b000) begin
      failures++;
      $display("FAIL rst_abandon got=%b want=000", {bus.csr_we, bus.busy, bus.redirect_valid});
    end
  endtask

  task automatic test_back_to_back;
    clear_inputs();
    bus.mstatus   = 32'h8;
    bus.mie       = 32'h80;
    bus.mtvec     = 32'h400;
    bus.trap_pc   = 32'h40;
    bus.irq_timer = 1'b1;
    tick();
    tick();
    bus.exc_valid = 1'b1;
    bus.exc_code  = 4'd1;
    tick();
    checks++;
    if ({bus.csr_waddr, bus.csr_wdata} !== {12'h300, 32'h1880}) begin
      failures++;
      $display("FAIL b2b_ignore got=%h/%h want=300/00001880", bus.csr_waddr, bus.csr_wdata);
    end
    bus.exc_valid = 1'b0;
    tick();
    checks++;
    if ({bus.redirect_valid, bus.redirect_pc, bus.busy, bus.stall} !== {1'b1, 32'h400, 1'b1, 1'b1}) begin
      failures++;
      $display("FAIL b2b_redirect got=rv%b pc%h busy%b st%b want=rv1 pc00000400 busy1 st1",
               bus.redirect_valid, bus.redirect_pc, bus.busy, bus.stall);
    end
    tick();
    checks++;
    if ({bus.busy, bus.stall, bus.redirect_valid} !== 3'b010) begin
      failures++;
      $display("FAIL b2b_reaccept got=busy%b st%b rv%b want=busy0 st1 rv0",
               bus.busy, bus.stall, bus.redirect_valid);
    end
    tick();
    bus.irq_timer = 1'b0;
    checks++;
    if ({bus.csr_we, bus.csr_waddr, bus.csr_wdata} !== {1'b1, 12'h341, 32'h40}) begin
      failures++;
      $display("FAIL b2b_second got=%b/%h/%h want=1/341/00000040",
               bus.csr_we, bus.csr_waddr, bus.csr_wdata);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if ({bus.busy, bus.stall} !== 2'b00) begin
      failures++;
      $display("FAIL b2b_settle got=%b want=00", {bus.busy, bus.stall});
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clear_inputs();
    test_reset();
    test_exception();
    test_irq_timer();
    test_irq_masked();
    test_irq_priority();
    test_mret();
    test_exc_mret_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
